// File: rtl/key_bounce_gen.sv
// key_bounce_gen: on request, drives key_o with a bouncing mechanical-key waveform.
// The sequence is press bounce, stable hold, release bounce, then a one-cycle done strobe.
// Every bounce pulse is shorter than the debouncer glitch window GLITCH.
// Optional macro KEY_BOUNCE_GEN_LFSR_EN: bounce pulse widths come from a 16-bit LFSR.
// When the macro is undefined, every pulse is GLITCH-1 cycles wide.
module key_bounce_gen #(
    parameter int unsigned CLK_FREQ_MHZ   = 150,
    parameter int unsigned GLITCH_TIME_NS = 100,
    parameter int unsigned BOUNCE_CNT     = 4,
    parameter int unsigned HOLD_W         = 16,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              press_req_i,
    input  logic [HOLD_W-1:0] hold_cycles_i,
    output logic              press_ready_o,
    output logic              key_o,
    output logic              done_stb_o,
    output logic [15:0]       press_cnt_o
);

    localparam int unsigned GLITCH   = GLITCH_TIME_NS * CLK_FREQ_MHZ / 1000;
    localparam int unsigned WCNT_W   = (GLITCH > 2) ? $clog2(GLITCH) : 1;
    localparam int unsigned HCNT_W   = HOLD_W + 1;
    localparam int unsigned HOLD_MIN = GLITCH + 2;

    // Reject parameter sets that cannot yield sub-glitch pulses or a valid sequence
    if (GLITCH < 2 || BOUNCE_CNT == 0 || BOUNCE_CNT > 255 || LFSR_SEED == 16'd0) begin : g_param_chk
        $error("key_bounce_gen: invalid parameters (GLITCH < 2, BOUNCE_CNT out of 1..255 or zero seed)");
    end

    typedef enum logic [2:0] {S_IDLE, S_PRESS, S_HOLD, S_REL, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [7:0]          pair_q, pair_d;
    logic                half_q, half_d;
    logic [HCNT_W-1:0]   hold_q, hold_d;
    logic                key_q, key_d;
    logic                done_q, done_d;
    logic                ready_q, ready_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [WCNT_W-1:0]   w_c;
    logic [HCNT_W-1:0]   hold_len_c;

`ifdef KEY_BOUNCE_GEN_LFSR_EN
    logic [15:0] lfsr_q;
    logic [7:0]  lfsr_lo;

    // Free-running Fibonacci LFSR, taps 16,14,13,11
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) lfsr_q <= LFSR_SEED;
        else         lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // Width of a pulse starting this cycle: low LFSR byte clamped to 1..GLITCH-1
    always_comb begin
        lfsr_lo = lfsr_q[7:0];
        if (lfsr_lo == 8'd0)                  w_c = WCNT_W'(1);
        else if (32'(lfsr_lo) > GLITCH - 1)   w_c = WCNT_W'(GLITCH - 1);
        else                                  w_c = WCNT_W'(lfsr_lo);
    end
`else
    // Fixed pulse width, one cycle short of the glitch window
    assign w_c = WCNT_W'(GLITCH - 1);
`endif

    // Hold duration is never shorter than GLITCH+2 so the debouncer sees a clean press
    assign hold_len_c = (HCNT_W'(hold_cycles_i) < HCNT_W'(HOLD_MIN)) ? HCNT_W'(HOLD_MIN)
                                                                    : HCNT_W'(hold_cycles_i);

    // State, counters and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            pair_q  <= '0;
            half_q  <= 1'b0;
            hold_q  <= '0;
            key_q   <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            pair_q  <= pair_d;
            half_q  <= half_d;
            hold_q  <= hold_d;
            key_q   <= key_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: segments count down from w-1; a pair is two segments of opposite level
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        pair_d  = pair_q;
        half_d  = half_q;
        hold_d  = hold_q;
        key_d   = key_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                key_d = 1'b0;
                if (press_req_i) begin
                    state_d = S_PRESS;
                    key_d   = 1'b1;
                    wcnt_d  = w_c - WCNT_W'(1);
                    pair_d  = '0;
                    half_d  = 1'b0;
                    hold_d  = hold_len_c;
                end
            end
            S_PRESS, S_REL: begin
                if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - WCNT_W'(1);
                end else if (!half_q) begin
                    half_d = 1'b1;
                    key_d  = ~key_q;
                    wcnt_d = w_c - WCNT_W'(1);
                end else if (pair_q == 8'(BOUNCE_CNT - 1)) begin
                    if (state_q == S_PRESS) begin
                        state_d = S_HOLD;
                        key_d   = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        key_d   = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    pair_d = pair_q + 8'd1;
                    half_d = 1'b0;
                    key_d  = ~key_q;
                    wcnt_d = w_c - WCNT_W'(1);
                end
            end
            S_HOLD: begin
                if (hold_q == HCNT_W'(1)) begin
                    state_d = S_REL;
                    key_d   = 1'b0;
                    wcnt_d  = w_c - WCNT_W'(1);
                    pair_d  = '0;
                    half_d  = 1'b0;
                end else begin
                    hold_d = hold_q - HCNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                key_d   = 1'b0;
                cnt_d   = cnt_q + 16'd1;
            end
            default: begin
                state_d = S_IDLE;
                key_d   = 1'b0;
            end
        endcase

        ready_d = (state_d == S_IDLE);
    end

    assign press_ready_o = ready_q;
    assign key_o         = key_q;
    assign done_stb_o    = done_q;
    assign press_cnt_o   = cnt_q;

endmodule
